hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
Consumer of the pipelined controller's hazard outputs (branchD, regwriteE, memtoregE, regwriteM, regwriteW) and of the datapath register indices. It produces forwarding selects, stalls and flushes for the 5-stage MIPS pipeline (F/D/E/M/W). It also adds a data-memory wait stall, a stall-cause state machine and a stall watchdog. Forwarding and stall outputs are combinational from the current inputs. The cause FSM, watchdog and error flag are registered.

Parameters:
MAX_STALL, 16, consecutive stall cycles that trigger hazard_err (range 2..255)
CNT_W, 32, width of the performance counters (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
rsD  in  5  source register rs, decode stage
rtD  in  5  source register rt, decode stage
rsE  in  5  source register rs, execute stage
rtE  in  5  source register rt, execute stage
writeregE  in  5  destination register, execute stage
writeregM  in  5  destination register, memory stage
writeregW  in  5  destination register, writeback stage
branchD  in  1  branch in decode (from controller)
regwriteE  in  1  register write pending, execute stage
memtoregE  in  1  load in execute stage
regwriteM  in  1  register write pending, memory stage
memtoregM  in  1  load in memory stage
regwriteW  in  1  register write pending, writeback stage
dmem_ready  in  1  data memory access complete this cycle
stallF  out  1  hold the PC
stallD  out  1  hold the F/D register
stallE  out  1  hold the D/E register
stallM  out  1  hold the E/M register
flushE  out  1  clear the D/E register
flushW  out  1  clear the M/W register
forwardAD  out  1  forward ALUOutM to the rs equality comparator
forwardBD  out  1  forward ALUOutM to the rt equality comparator
forwardAE  out  2  ALU operand A select: 00 register file, 01 ResultW, 10 ALUOutM
forwardBE  out  2  ALU operand B select: same encoding as forwardAE
stall_cause  out  2  registered stall cause: 00 none, 01 load-use, 10 branch, 11 mem-wait
hazard_err  out  1  sticky watchdog error

Behaviour:
- Register $0 never matches: any compare against index 0 is false.
- forwardAE = 10 if regwriteM and rsE==writeregM; else 01 if regwriteW and rsE==writeregW; else 00. M takes priority over W. forwardBE uses rtE with the same rule.
- forwardAD = regwriteM & (rsD==writeregM). forwardBD = regwriteM & (rtD==writeregM).
- lwstall = memtoregE & (rsD==writeregE | rtD==writeregE).
- brstall = branchD & ((regwriteE & writeregE∈{rsD,rtD}) | (memtoregM & writeregM∈{rsD,rtD})).
- memwait = memtoregM & ~dmem_ready. Store wait is out of scope.
- Priority is memwait > lwstall > brstall.
- memwait: stallF=stallD=stallE=stallM=1, flushW=1, flushE=0.
- lwstall or brstall (no memwait): stallF=stallD=1, flushE=1, stallE=stallM=flushW=0.
- No hazard: all stall/flush outputs 0.
- FSM states RUN, LDUSE, BRSTALL, MEMWAIT. Each clock the next state is the highest-priority active cause, else RUN. stall_cause encodes the state (1-cycle latency).
- Watchdog: stall_cnt (8 bit) increments on each cycle with any stall active, saturating at MAX_STALL. It clears to 0 on any non-stall cycle.
- When stall_cnt reaches MAX_STALL, hazard_err is set and stays 1 until reset. Stall behaviour is unaffected.
- Reset (async, any time, including mid-stall): state=RUN, stall_cnt=0, hazard_err=0, stall_cause=00.
- While reset is high, all stall/flush/forward outputs are forced to 0.

Optional Feature:
Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs perf_stall_cnt and perf_flush_cnt (CNT_W each, reset to 0).
  - perf_stall_cnt increments on every cycle with stallF=1.
  - perf_flush_cnt increments on every cycle with flushE=1 or flushW=1.
  - Both wrap modulo 2^CNT_W.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
1. regwriteM=1, writeregM=8, rsE=8, regwriteW=1, writeregW=8 -> forwardAE=10; set writeregM=9 -> forwardAE=01; rsE=0 with writeregM=0, regwriteM=1 -> forwardAE=00.
2. memtoregE=1, writeregE=5, rtD=5 -> stallF=stallD=flushE=1, stallE=0; next cycle stall_cause=01.
3. branchD=1, regwriteE=1, writeregE=3, rsD=3 -> stallF=1, flushE=1, stall_cause=10 next cycle. Then move the writer to M (regwriteM=1, memtoregM=0, writeregM=3) -> no stall, forwardAD=1.
4. memtoregM=1, dmem_ready=0 for 3 cycles with a concurrent lwstall -> stallF..stallM=1, flushW=1, flushE=0, stall_cause=11. dmem_ready=1 -> memwait drops; the load-use stall shows only if it is still present.
5. MAX_STALL=4, memwait held 4 cycles -> hazard_err=1 after the 4th stalled edge and stays 1 after stalls end; assert reset mid-stall -> hazard_err=0, stall_cause=00 immediately.
6. With HAZARD_PERF_CNT_EN defined: 3 load-use cycles plus 2 memwait cycles -> perf_stall_cnt=5, perf_flush_cnt=5.

Source files
------------

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: pipeline hazard inputs and forward/stall/flush controls for hazard_unit.
// HAZARD_PERF_CNT_EN adds the performance counter outputs.
interface hazard_unit_if #(parameter int CNT_W = 32);
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic branchD, regwriteE, memtoregE, regwriteM, memtoregM, regwriteW, dmem_ready;
    logic stallF, stallD, stallE, stallM, flushE, flushW, forwardAD, forwardBD;
    logic [1:0] forwardAE, forwardBE, stall_cause;
    logic hazard_err;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] perf_stall_cnt, perf_flush_cnt;
`endif
    modport master (
        output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
        output branchD, regwriteE, memtoregE, regwriteM, memtoregM, regwriteW, dmem_ready,
        input stallF, stallD, stallE, stallM, flushE, flushW, forwardAD, forwardBD,
        input forwardAE, forwardBE, stall_cause, hazard_err
`ifdef HAZARD_PERF_CNT_EN
        , input perf_stall_cnt, perf_flush_cnt
`endif
    );
    modport slave (
        input rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
        input branchD, regwriteE, memtoregE, regwriteM, memtoregM, regwriteW, dmem_ready,
        output stallF, stallD, stallE, stallM, flushE, flushW, forwardAD, forwardBD,
        output forwardAE, forwardBE, stall_cause, hazard_err
`ifdef HAZARD_PERF_CNT_EN
        , output perf_stall_cnt, perf_flush_cnt
`endif
    );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: forwarding, stall/flush, stall-cause FSM and stall watchdog for a 5-stage MIPS pipeline.
// Optional HAZARD_PERF_CNT_EN adds stall/flush performance counters.
module hazard_unit #(
    parameter int MAX_STALL = 16,
    parameter int CNT_W = 32
) (
    input logic clk,
    input logic reset,
    hazard_unit_if.slave hz
);
    typedef enum logic [1:0] {RUN = 2'b00, LDUSE = 2'b01, BRSTALL = 2'b10, MEMWAIT = 2'b11} state_t;
    state_t state_q, state_d;
    logic [7:0] stall_cnt_q, stall_cnt_d;
    logic hazard_err_q, hazard_err_d;
    logic lwstall, brstall, memwait, any_stall;

    if (CNT_W < 1 || MAX_STALL < 2 || MAX_STALL > 255) begin : g_bad_param
        $error("hazard_unit: parameter out of range");
    end

    // $0 is hard-wired, so it never creates a dependency
    function automatic logic hit(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] r);
        return (hz.regwriteM && hit(r, hz.writeregM)) ? 2'b10 :
               (hz.regwriteW && hit(r, hz.writeregW)) ? 2'b01 : 2'b00;
    endfunction

    assign memwait = hz.memtoregM & ~hz.dmem_ready;
    assign lwstall = hz.memtoregE & (hit(hz.rsD, hz.writeregE) | hit(hz.rtD, hz.writeregE));
    assign brstall = hz.branchD &
                     ((hz.regwriteE & (hit(hz.rsD, hz.writeregE) | hit(hz.rtD, hz.writeregE))) |
                      (hz.memtoregM & (hit(hz.rsD, hz.writeregM) | hit(hz.rtD, hz.writeregM))));
    assign any_stall = memwait | lwstall | brstall;

    assign hz.stallF = ~reset & any_stall;
    assign hz.stallD = ~reset & any_stall;
    assign hz.stallE = ~reset & memwait;
    assign hz.stallM = ~reset & memwait;
    assign hz.flushW = ~reset & memwait;
    assign hz.flushE = ~reset & ~memwait & (lwstall | brstall);
    assign hz.forwardAD = ~reset & hz.regwriteM & hit(hz.rsD, hz.writeregM);
    assign hz.forwardBD = ~reset & hz.regwriteM & hit(hz.rtD, hz.writeregM);
    assign hz.forwardAE = reset ? 2'b00 : fwd_sel(hz.rsE);
    assign hz.forwardBE = reset ? 2'b00 : fwd_sel(hz.rtE);
    assign hz.stall_cause = state_q;
    assign hz.hazard_err = hazard_err_q;

    always_comb begin
        state_d = memwait ? MEMWAIT : lwstall ? LDUSE : brstall ? BRSTALL : RUN;
        stall_cnt_d = !any_stall ? 8'd0 :
                      (stall_cnt_q == 8'(MAX_STALL)) ? stall_cnt_q : stall_cnt_q + 8'd1;
        hazard_err_d = hazard_err_q | (stall_cnt_d == 8'(MAX_STALL));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            stall_cnt_q <= 8'd0;
            hazard_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            stall_cnt_q <= stall_cnt_d;
            hazard_err_q <= hazard_err_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] perf_stall_q, perf_stall_d, perf_flush_q, perf_flush_d;

    always_comb begin
        perf_stall_d = perf_stall_q + (hz.stallF ? CNT_W'(1) : CNT_W'(0));
        perf_flush_d = perf_flush_q + ((hz.flushE | hz.flushW) ? CNT_W'(1) : CNT_W'(0));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign hz.perf_stall_cnt = perf_stall_q;
    assign hz.perf_flush_cnt = perf_flush_q;
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: table vectors, hand sequences and randomized traffic against a reference model.
module tb_hazard_unit;
    localparam int MAXS = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hazard_unit_if bus ();
    hazard_unit #(.MAX_STALL(MAXS)) dut (.clk(clk), .reset(reset), .hz(bus.slave));

    typedef struct packed {
        logic [4:0] rsD, rtD, rsE, rtE, wE, wM, wW;
        logic br, rwE, mtrE, rwM, mtrM, rwW, rdy;
        logic [5:0] sf;
        logic [1:0] fd;
        logic [3:0] fe;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int exp_cause = 0;
    int run = 0;
    bit exp_err = 0;
    longint perf_s = 0;
    longint perf_f = 0;
    vec_t tbl[11];
    vec_t v;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", n, got, exp, $time);
        end
    endtask

    function automatic bit hit(input logic [4:0] a, input logic [4:0] b);
        return a != 0 && a == b;
    endfunction

    function automatic logic [1:0] fsel(input logic [4:0] r);
        if (bus.regwriteM && hit(r, bus.writeregM)) return 2'd2;
        if (bus.regwriteW && hit(r, bus.writeregW)) return 2'd1;
        return 2'd0;
    endfunction

    task automatic model(output logic [5:0] sf, output logic [1:0] fd, output logic [3:0] fe, output int c);
        bit lw, br, mw;
        lw = bus.memtoregE && (hit(bus.rsD, bus.writeregE) || hit(bus.rtD, bus.writeregE));
        br = bus.branchD && ((bus.regwriteE && (hit(bus.rsD, bus.writeregE) || hit(bus.rtD, bus.writeregE))) ||
                             (bus.memtoregM && (hit(bus.rsD, bus.writeregM) || hit(bus.rtD, bus.writeregM))));
        mw = bus.memtoregM && !bus.dmem_ready;
        c = mw ? 3 : lw ? 1 : br ? 2 : 0;
        sf = (c == 3) ? 6'b111101 : (c != 0) ? 6'b110010 : 6'b000000;
        fd = {bus.regwriteM && hit(bus.rsD, bus.writeregM), bus.regwriteM && hit(bus.rtD, bus.writeregM)};
        fe = {fsel(bus.rsE), fsel(bus.rtE)};
        if (reset) begin
            sf = '0;
            fd = '0;
            fe = '0;
        end
    endtask

    task automatic set_in(input vec_t x);
        bus.rsD = x.rsD; bus.rtD = x.rtD; bus.rsE = x.rsE; bus.rtE = x.rtE;
        bus.writeregE = x.wE; bus.writeregM = x.wM; bus.writeregW = x.wW;
        bus.branchD = x.br; bus.regwriteE = x.rwE; bus.memtoregE = x.mtrE;
        bus.regwriteM = x.rwM; bus.memtoregM = x.mtrM; bus.regwriteW = x.rwW;
        bus.dmem_ready = x.rdy;
    endtask

    function automatic logic [5:0] sf_act();
        return {bus.stallF, bus.stallD, bus.stallE, bus.stallM, bus.flushE, bus.flushW};
    endfunction

    task automatic model_reset();
        exp_cause = 0; run = 0; exp_err = 0; perf_s = 0; perf_f = 0;
    endtask

    // Called at a falling edge with inputs applied; returns at the next falling edge.
    task automatic cycle();
        logic [5:0] sf;
        logic [1:0] fd;
        logic [3:0] fe;
        int c;
        model(sf, fd, fe, c);
        #1;
        chk("stall_flush", 32'(sf_act()), 32'(sf));
        chk("fwd_D", 32'({bus.forwardAD, bus.forwardBD}), 32'(fd));
        chk("fwd_E", 32'({bus.forwardAE, bus.forwardBE}), 32'(fe));
        @(posedge clk);
        if (!reset) begin
            exp_cause = c;
            run = sf[5] ? run + 1 : 0;
            if (run >= MAXS) exp_err = 1;
            perf_s += sf[5];
            perf_f += (sf[1] | sf[0]);
        end
        #1;
        chk("stall_cause", 32'(bus.stall_cause), 32'(exp_cause));
        chk("hazard_err", 32'(bus.hazard_err), 32'(exp_err));
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_stall", bus.perf_stall_cnt, 32'(perf_s));
        chk("perf_flush", bus.perf_flush_cnt, 32'(perf_f));
`endif
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in('{rdy: 1'b1, default: '0});
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_cause", 32'(bus.stall_cause), 32'd0);
        chk("rst_err", 32'(bus.hazard_err), 32'd0);
        chk("rst_sf", 32'(sf_act()), 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{rsE: 8, wM: 8, rwM: 1, wW: 8, rwW: 1, rdy: 1, fe: 4'b1000, default: '0};
        tbl[1]  = '{rsE: 8, wM: 9, rwM: 1, wW: 8, rwW: 1, rdy: 1, fe: 4'b0100, default: '0};
        tbl[2]  = '{rsE: 0, wM: 0, rwM: 1, wW: 0, rwW: 1, rdy: 1, fe: 4'b0000, default: '0};
        tbl[3]  = '{rtE: 7, wW: 7, rwW: 1, rdy: 1, fe: 4'b0001, default: '0};
        tbl[4]  = '{mtrE: 1, rwE: 1, wE: 5, rtD: 5, rdy: 1, sf: 6'b110010, default: '0};
        tbl[5]  = '{br: 1, rwE: 1, wE: 3, rsD: 3, rdy: 1, sf: 6'b110010, default: '0};
        tbl[6]  = '{br: 1, rwM: 1, wM: 3, rsD: 3, rdy: 1, fd: 2'b10, default: '0};
        tbl[7]  = '{br: 1, mtrM: 1, rwM: 1, wM: 4, rtD: 4, rdy: 1, sf: 6'b110010, fd: 2'b01, default: '0};
        tbl[8]  = '{mtrM: 1, rdy: 0, mtrE: 1, wE: 6, rsD: 6, sf: 6'b111101, default: '0};
        tbl[9]  = '{mtrE: 1, wE: 0, rsD: 0, rdy: 1, default: '0};
        tbl[10] = '{rwE: 1, wE: 3, rsD: 3, rdy: 1, default: '0};

        do_reset();
        foreach (tbl[i]) begin
            set_in(tbl[i]);
            #1;
            chk($sformatf("tbl%0d_sf", i), 32'(sf_act()), 32'(tbl[i].sf));
            chk($sformatf("tbl%0d_fd", i), 32'({bus.forwardAD, bus.forwardBD}), 32'(tbl[i].fd));
            chk($sformatf("tbl%0d_fe", i), 32'({bus.forwardAE, bus.forwardBE}), 32'(tbl[i].fe));
            cycle();
            if (i == 4) chk("lu_cause", 32'(bus.stall_cause), 32'd1);
            if (i == 5) chk("br_cause", 32'(bus.stall_cause), 32'd2);
        end

        // memwait over a concurrent load-use, then memory returns with the load-use still live
        do_reset();
        set_in('{mtrM: 1, rdy: 0, mtrE: 1, wE: 6, rsD: 6, default: '0});
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("mw_cause", 32'(bus.stall_cause), 32'd3);
        end
        bus.dmem_ready = 1'b1;
        #1;
        chk("mw_release_sf", 32'(sf_act()), 32'b110010);
        cycle();
        chk("mw_release_cause", 32'(bus.stall_cause), 32'd1);
        chk("mw_err4", 32'(bus.hazard_err), 32'd1);

        // watchdog and async reset mid-stall
        do_reset();
        set_in('{mtrM: 1, rdy: 0, default: '0});
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("wd_pre", 32'(bus.hazard_err), 32'd0);
        end
        cycle();
        chk("wd_set", 32'(bus.hazard_err), 32'd1);
        set_in('{rdy: 1, default: '0});
        cycle();
        chk("wd_sticky", 32'(bus.hazard_err), 32'd1);
        chk("wd_idle_cause", 32'(bus.stall_cause), 32'd0);
        set_in('{mtrM: 1, rdy: 0, rsE: 2, wM: 2, rwM: 1, default: '0});
        cycle();
        reset = 1'b1;
        #1;
        chk("mid_rst_err", 32'(bus.hazard_err), 32'd0);
        chk("mid_rst_cause", 32'(bus.stall_cause), 32'd0);
        chk("mid_rst_sf", 32'(sf_act()), 32'd0);
        chk("mid_rst_fwd", 32'({bus.forwardAE, bus.forwardBE}), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

`ifdef HAZARD_PERF_CNT_EN
        do_reset();
        set_in('{mtrE: 1, wE: 5, rtD: 5, rdy: 1, default: '0});
        for (int k = 0; k < 3; k++) cycle();
        set_in('{mtrM: 1, rdy: 0, default: '0});
        for (int k = 0; k < 2; k++) cycle();
        set_in('{rdy: 1, default: '0});
        cycle();
        chk("perf_stall_5", bus.perf_stall_cnt, 32'd5);
        chk("perf_flush_5", bus.perf_flush_cnt, 32'd5);
`endif

        // randomized traffic over a small register range so matches are frequent
        for (int n = 0; n < 400; n++) begin
            if (n % 60 == 0) do_reset();
            v = '0;
            v.rsD = 5'($urandom_range(0, 3)); v.rtD = 5'($urandom_range(0, 3));
            v.rsE = 5'($urandom_range(0, 3)); v.rtE = 5'($urandom_range(0, 3));
            v.wE = 5'($urandom_range(0, 3)); v.wM = 5'($urandom_range(0, 3));
            v.wW = 5'($urandom_range(0, 3));
            v.br = 1'($urandom); v.rwE = 1'($urandom); v.mtrE = 1'($urandom_range(0, 2) == 0);
            v.rwM = 1'($urandom); v.mtrM = 1'($urandom); v.rwW = 1'($urandom);
            v.rdy = 1'($urandom_range(0, 3) != 0);
            set_in(v);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
